// File: rtl/gate_vector_checker.sv
// ---------------------------------------------------------------------------
// gate_vector_checker
//
// Clocked stimulus/response sequencer for a 2-input gate under test. It
// drives {a,b} through 00, 01, 10, 11, waits SETTLE_CYCLES for the gate to
// settle, samples y and compares it with the truth table chosen by gate_sel.
// Mismatches are counted in a saturating counter. A run is NUM_PASSES full
// sweeps long.
//
// Parameters
//   SETTLE_CYCLES  cycles held in WAIT before y is sampled (>=1)
//   NUM_PASSES     full 4-vector sweeps per start (1..15)
//   ERR_W          err_cnt_o width; the counter saturates at all-ones
//
// Ports
//   clk_i             rising-edge clock
//   rst_i             synchronous reset, active-high (wins over start_i)
//   start_i           1-cycle run request, honoured only in IDLE
//   gate_sel_i [2:0]  0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 NOT a,
//                     7 BUF a; latched at start
//   y_i               output of the gate under test, sampled in SAMPLE
//   a_o, b_o          registered gate inputs; change only on leaving DRIVE
//   vec_idx_o  [1:0]  index {a,b} of the vector being driven
//   busy_o            high in DRIVE, WAIT and SAMPLE
//   done_o            1-cycle pulse while in DONE
//   pass_o            1 iff err_cnt_o==0, updated on entry to DONE and held
//                     until the next start
//   err_cnt_o         saturating mismatch count
//
// Optional build (macro ERR_LOG_EN)
//   first_fail_idx_o [1:0]  vector index of the first mismatch of the run
//   first_fail_y_o          y value observed at that first mismatch
//   fail_seen_o             set together with the capture above
//   All three freeze after capture and clear on start and on reset. When
//   ERR_LOG_EN is not defined these ports and registers do not exist.
// ---------------------------------------------------------------------------
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       gate_sel_i,
    input  logic             y_i,
    output logic             a_o,
    output logic             b_o,
    output logic [1:0]       vec_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o
`ifdef ERR_LOG_EN
    ,
    output logic [1:0]       first_fail_idx_o,
    output logic             first_fail_y_o,
    output logic             fail_seen_o
`endif
);

    // WAIT counts 0 .. SETTLE_CYCLES-1; keep at least one bit.
    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]        PASS_LAST = 4'(NUM_PASSES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t             state_q;
    logic [2:0]         sel_q;
    logic               a_q;
    logic               b_q;
    logic [1:0]         vec_idx_q;
    logic [3:0]         pass_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic [ERR_W-1:0]   err_cnt_d;
    logic               exp_y;
    logic               mismatch;

`ifdef ERR_LOG_EN
    logic [1:0]         first_fail_idx_q;
    logic               first_fail_y_q;
    logic               fail_seen_q;
`endif

    // Truth table of the selected gate. NOT a / BUF a ignore b.
    function automatic logic gate_eval(input logic [2:0] sel,
                                       input logic       a,
                                       input logic       b);
        logic r;
        case (sel)
            3'd0:    r = ~(a & b);
            3'd1:    r = ~(a | b);
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // The expected value uses the registered a/b, which are exactly what
    // the gate under test has been seeing since the end of DRIVE.
    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally), otherwise a latch is inferred.
    always_comb begin
        exp_y     = gate_eval(sel_q, a_q, b_q);
        mismatch  = (y_i != exp_y);
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            sel_q      <= 3'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            vec_idx_q  <= 2'd0;
            pass_cnt_q <= 4'd0;
            wait_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
`ifdef ERR_LOG_EN
            first_fail_idx_q <= 2'd0;
            first_fail_y_q   <= 1'b0;
            fail_seen_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_DRIVE;
                        sel_q      <= gate_sel_i;
                        err_cnt_q  <= '0;
                        pass_q     <= 1'b0;
                        vec_idx_q  <= 2'd0;
                        pass_cnt_q <= 4'd0;
                        busy_q     <= 1'b1;
`ifdef ERR_LOG_EN
                        first_fail_idx_q <= 2'd0;
                        first_fail_y_q   <= 1'b0;
                        fail_seen_q      <= 1'b0;
`endif
                    end
                end

                ST_DRIVE: begin
                    a_q        <= vec_idx_q[1];
                    b_q        <= vec_idx_q[0];
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    err_cnt_q <= err_cnt_d;
`ifdef ERR_LOG_EN
                    // Capture only the first mismatch of the run.
                    if (mismatch && !fail_seen_q) begin
                        first_fail_idx_q <= vec_idx_q;
                        first_fail_y_q   <= y_i;
                        fail_seen_q      <= 1'b1;
                    end
`endif
                    if (vec_idx_q != 2'd3) begin
                        vec_idx_q <= vec_idx_q + 2'd1;
                        state_q   <= ST_DRIVE;
                    end else if (pass_cnt_q != PASS_LAST) begin
                        vec_idx_q  <= 2'd0;
                        pass_cnt_q <= pass_cnt_q + 4'd1;
                        state_q    <= ST_DRIVE;
                    end else begin
                        // Verdict uses the count including this last sample.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign vec_idx_o = vec_idx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_cnt_q;

`ifdef ERR_LOG_EN
    assign first_fail_idx_o = first_fail_idx_q;
    assign first_fail_y_o   = first_fail_y_q;
    assign fail_seen_o      = fail_seen_q;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_vector_checker
//
// Directed bench for gate_vector_checker. Three instances share clock and
// reset:
//   u_dut     default parameters; y comes from a selectable gate model
//   u_dut_np  NUM_PASSES=15; y tied high (AND target -> saturation)
//   u_dut_s1  SETTLE_CYCLES=1; y from an XOR model
// Cycle numbering inside a run: cycle 0 is the first cycle in DRIVE.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gate_vector_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- main instance ----------------
    logic       start;
    logic [2:0] gate_sel;
    logic       y;
    logic       a, b, busy, done, pass;
    logic [1:0] vec_idx;
    logic [3:0] err_cnt;
    int         y_mode;   // 0 NOR model, 1 forced 0, 2 forced 1, 3 XOR model

    always_comb begin
        case (y_mode)
            0:       y = ~(a | b);
            1:       y = 1'b0;
            2:       y = 1'b1;
            default: y = a ^ b;
        endcase
    end

`ifdef ERR_LOG_EN
    logic [1:0] ff_idx, ff_idx_np, ff_idx_s1;
    logic       ff_y, ff_y_np, ff_y_s1;
    logic       fseen, fseen_np, fseen_s1;
`endif

    gate_vector_checker u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .gate_sel_i (gate_sel),
        .y_i        (y),
        .a_o        (a),
        .b_o        (b),
        .vec_idx_o  (vec_idx),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .err_cnt_o  (err_cnt)
`ifdef ERR_LOG_EN
        ,
        .first_fail_idx_o (ff_idx),
        .first_fail_y_o   (ff_y),
        .fail_seen_o      (fseen)
`endif
    );

    // ---------------- 15-pass instance ----------------
    logic       start_np;
    logic [2:0] gate_sel_np;
    logic       y_np;
    logic       a_np, b_np, busy_np, done_np, pass_np;
    logic [1:0] vec_idx_np;
    logic [3:0] err_cnt_np;

    assign y_np = 1'b1;

    gate_vector_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(15), .ERR_W(4)) u_dut_np (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_np),
        .gate_sel_i (gate_sel_np),
        .y_i        (y_np),
        .a_o        (a_np),
        .b_o        (b_np),
        .vec_idx_o  (vec_idx_np),
        .busy_o     (busy_np),
        .done_o     (done_np),
        .pass_o     (pass_np),
        .err_cnt_o  (err_cnt_np)
`ifdef ERR_LOG_EN
        ,
        .first_fail_idx_o (ff_idx_np),
        .first_fail_y_o   (ff_y_np),
        .fail_seen_o      (fseen_np)
`endif
    );

    // ---------------- settle=1 instance ----------------
    logic       start_s1;
    logic [2:0] gate_sel_s1;
    logic       y_s1;
    logic       a_s1, b_s1, busy_s1, done_s1, pass_s1;
    logic [1:0] vec_idx_s1;
    logic [3:0] err_cnt_s1;

    assign y_s1 = a_s1 ^ b_s1;

    gate_vector_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(1), .ERR_W(4)) u_dut_s1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_s1),
        .gate_sel_i (gate_sel_s1),
        .y_i        (y_s1),
        .a_o        (a_s1),
        .b_o        (b_s1),
        .vec_idx_o  (vec_idx_s1),
        .busy_o     (busy_s1),
        .done_o     (done_s1),
        .pass_o     (pass_s1),
        .err_cnt_o  (err_cnt_s1)
`ifdef ERR_LOG_EN
        ,
        .first_fail_idx_o (ff_idx_s1),
        .first_fail_y_o   (ff_y_s1),
        .fail_seen_o      (fseen_s1)
`endif
    );

    // Pulse start on the main instance and observe a fixed window of cycles.
    // inj0/inj1: cycles at which start is re-asserted (-1 = never).
    // ab_seq/vi_seq: {a,b} and vec_idx sampled in WAIT of vectors 0..3.
    task automatic run_main(input int budget, input int inj0, input int inj1,
                            output int first_done, output int done_cnt,
                            output logic [7:0] ab_seq, output logic [7:0] vi_seq,
                            output logic busy_after);
        first_done = -1;
        done_cnt   = 0;
        ab_seq     = 8'h00;
        vi_seq     = 8'h00;
        busy_after = 1'bx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            start = (c == inj0) || (c == inj1);
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = c;
            end
            if ((c % 4 == 2) && (c < 16)) begin
                ab_seq[7 - 2*(c/4) -: 2] = {a, b};
                vi_seq[7 - 2*(c/4) -: 2] = vec_idx;
            end
            if (c == 17) busy_after = busy;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({a, b} !== 2'b00)   begin bad++; $display("FAIL reset_ab: got %b want 00", {a, b}); end
        total++; if (vec_idx !== 2'd0)   begin bad++; $display("FAIL reset_vec_idx: got %0d want 0", vec_idx); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL reset_pass: got %b want 0", pass); end
        total++; if (err_cnt !== 4'd0)   begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        total++; if ({busy_np, busy_s1} !== 2'b00) begin bad++; $display("FAIL reset_busy_others: got %b want 00", {busy_np, busy_s1}); end
`ifdef ERR_LOG_EN
        total++; if ({fseen, ff_idx, ff_y} !== 4'b0) begin bad++; $display("FAIL reset_errlog: got %b want 0000", {fseen, ff_idx, ff_y}); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nor_sweep();
        int fd, dc;
        logic [7:0] abs, vis;
        logic ba;
        y_mode = 0; gate_sel = 3'd1;
        run_main(24, -1, -1, fd, dc, abs, vis, ba);
        total++; if (fd !== 16)          begin bad++; $display("FAIL nor_done_cycle: got %0d want 16", fd); end
        total++; if (dc !== 1)           begin bad++; $display("FAIL nor_done_width: got %0d want 1", dc); end
        total++; if (abs !== 8'h1B)      begin bad++; $display("FAIL nor_ab_seq: got %h want 1b", abs); end
        total++; if (vis !== 8'h1B)      begin bad++; $display("FAIL nor_vec_seq: got %h want 1b", vis); end
        total++; if (err_cnt !== 4'd0)   begin bad++; $display("FAIL nor_err_cnt: got %0d want 0", err_cnt); end
        total++; if (pass !== 1'b1)      begin bad++; $display("FAIL nor_pass: got %b want 1", pass); end
        total++; if (ba !== 1'b0)        begin bad++; $display("FAIL nor_busy_after: got %b want 0", ba); end
        total++; if ({a, b} !== 2'b11)   begin bad++; $display("FAIL nor_ab_hold: got %b want 11", {a, b}); end
    endtask

    task automatic test_force0();
        y_mode = 1; gate_sel = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Cycle 0 in DRIVE: the previous verdict must already be cleared.
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL force0_pass_cleared: got %b want 0", pass); end
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL force0_busy: got %b want 1", busy); end
        repeat (16) @(negedge clk);
        total++; if (done !== 1'b1)      begin bad++; $display("FAIL force0_done: got %b want 1", done); end
        total++; if (err_cnt !== 4'd1)   begin bad++; $display("FAIL force0_err_cnt: got %0d want 1", err_cnt); end
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL force0_pass: got %b want 0", pass); end
`ifdef ERR_LOG_EN
        total++; if ({fseen, ff_idx, ff_y} !== 4'b1000) begin bad++; $display("FAIL force0_errlog: got %b want 1000", {fseen, ff_idx, ff_y}); end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_saturate();
        int fd = -1;
        gate_sel_np = 3'd2;
        start_np = 1'b1;
        @(negedge clk);
        start_np = 1'b0;
        for (int c = 0; c < 260; c++) begin
            if (done_np === 1'b1 && fd < 0) fd = c;
            @(negedge clk);
        end
        total++; if (fd !== 240)         begin bad++; $display("FAIL sat_done_cycle: got %0d want 240", fd); end
        total++; if (err_cnt_np !== 4'd15) begin bad++; $display("FAIL sat_err_cnt: got %0d want 15", err_cnt_np); end
        total++; if (pass_np !== 1'b0)   begin bad++; $display("FAIL sat_pass: got %b want 0", pass_np); end
    endtask

    task automatic test_start_ignored();
        int fd, dc;
        logic [7:0] abs, vis;
        logic ba;
        y_mode = 0; gate_sel = 3'd1;
        // Re-pulse start in WAIT of vector 2 (cycle 9) and in DONE (cycle 16).
        run_main(30, 9, 16, fd, dc, abs, vis, ba);
        total++; if (fd !== 16)          begin bad++; $display("FAIL ign_done_cycle: got %0d want 16", fd); end
        total++; if (dc !== 1)           begin bad++; $display("FAIL ign_done_count: got %0d want 1", dc); end
        total++; if (vis !== 8'h1B)      begin bad++; $display("FAIL ign_vec_seq: got %h want 1b", vis); end
        total++; if (ba !== 1'b0)        begin bad++; $display("FAIL ign_busy_after_done: got %b want 0", ba); end
        total++; if (pass !== 1'b1)      begin bad++; $display("FAIL ign_pass: got %b want 1", pass); end
    endtask

    task automatic test_reset_mid_run();
        int dcnt = 0;
        int bcnt = 0;
        int fd, dc;
        logic [7:0] abs, vis;
        logic ba;
        y_mode = 1; gate_sel = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        // Cycle 7: SAMPLE of vector 1, one mismatch already counted.
        total++; if ({a, b, err_cnt} !== 6'b01_0001) begin bad++; $display("FAIL rst_pre: got %b want 010001", {a, b, err_cnt}); end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        total++; if ({busy, a, b, done} !== 4'b0000) begin bad++; $display("FAIL rst_mid_outputs: got %b want 0000", {busy, a, b, done}); end
        total++; if (err_cnt !== 4'd0)   begin bad++; $display("FAIL rst_mid_err_cnt: got %0d want 0", err_cnt); end
        total++; if (vec_idx !== 2'd0)   begin bad++; $display("FAIL rst_mid_vec_idx: got %0d want 0", vec_idx); end
`ifdef ERR_LOG_EN
        total++; if (fseen !== 1'b0)     begin bad++; $display("FAIL rst_mid_fail_seen: got %b want 0", fseen); end
`endif
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1) dcnt++;
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
        end
        total++; if (dcnt !== 0)         begin bad++; $display("FAIL rst_no_done: got %0d want 0", dcnt); end
        total++; if (bcnt !== 0)         begin bad++; $display("FAIL rst_wins_start: got %0d busy cycles want 0", bcnt); end
        y_mode = 0;
        run_main(24, -1, -1, fd, dc, abs, vis, ba);
        total++; if (fd !== 16)          begin bad++; $display("FAIL rst_rerun_done: got %0d want 16", fd); end
        total++; if (err_cnt !== 4'd0)   begin bad++; $display("FAIL rst_rerun_err: got %0d want 0", err_cnt); end
        total++; if (pass !== 1'b1)      begin bad++; $display("FAIL rst_rerun_pass: got %b want 1", pass); end
    endtask

    task automatic test_settle1();
        int fd = -1;
        logic [7:0] abs = 8'h00;
        gate_sel_s1 = 3'd4;
        start_s1 = 1'b1;
        @(negedge clk);
        start_s1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            // Switching to XNOR mid-run must not affect the latched selection.
            if (c == 4) gate_sel_s1 = 3'd5;
            if (done_s1 === 1'b1 && fd < 0) fd = c;
            if ((c % 3 == 2) && (c < 12)) abs[7 - 2*(c/3) -: 2] = {a_s1, b_s1};
            @(negedge clk);
        end
        total++; if (fd !== 12)          begin bad++; $display("FAIL s1_done_cycle: got %0d want 12", fd); end
        total++; if (abs !== 8'h1B)      begin bad++; $display("FAIL s1_ab_seq: got %h want 1b", abs); end
        total++; if (err_cnt_s1 !== 4'd0) begin bad++; $display("FAIL s1_err_cnt: got %0d want 0", err_cnt_s1); end
        total++; if (pass_s1 !== 1'b1)   begin bad++; $display("FAIL s1_pass: got %b want 1", pass_s1); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; start_np = 1'b0; start_s1 = 1'b0;
        gate_sel = 3'd0; gate_sel_np = 3'd0; gate_sel_s1 = 3'd0;
        y_mode = 0;
        @(negedge clk);
        test_reset();
        test_nor_sweep();
        test_force0();
        test_saturate();
        test_start_ignored();
        test_reset_mid_run();
        test_settle1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
